sweep_counter_ctrl: RTL and testbench
=====================================

Name: sweep_counter_ctrl

Overview:
- Sequencer that drives a bounded up/down counter through programmable triangle sweeps: up from lo to hi, optional dwell, down to lo, optional dwell, repeated num_sweeps times.
- Sits between the configuration/control logic and the counter consumer, such as a test-pattern or PWM ramp generator.
- Owns the count register, the direction flag and the sweep bookkeeping.
- Reports busy, done and configuration errors.

Parameters:
- WIDTH, 4: width of count, lo and hi.
- DWELL_W, 4: width of the dwell-length field.
- SWEEP_W, 8: width of num_sweeps and sweep_cnt.

Ports:
- clk  input  1  system clock; all logic is on the rising edge.
- reset_n  input  1  synchronous, active-low reset.
- start  input  1  request to begin a run; sampled only in IDLE.
- abort  input  1  stop the run; the next edge returns the block to IDLE.
- lo  input  WIDTH  lower sweep bound; latched at start.
- hi  input  WIDTH  upper sweep bound; latched at start.
- dwell  input  DWELL_W  extra hold cycles at each end point; latched at start.
- num_sweeps  input  SWEEP_W  number of full up+down sweeps; latched at start.
- count  output  WIDTH  current counter value (registered).
- up_down  output  1  direction flag: 1 = up or next motion up, 0 = down or next motion down.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse when the final sweep completes.
- cfg_err  output  1  one-cycle pulse when start is rejected.
- sweep_cnt  output  SWEEP_W  completed sweeps in the current or most recent run.

Behaviour:
- Reset (reset_n=0 at an edge): highest priority in every state.
  - state = IDLE, count = 0, up_down = 1.
  - busy = 0, done = 0, cfg_err = 0, sweep_cnt = 0.
  - All latched configuration = 0.
- States: IDLE, UP, DWELL_HI, DOWN, DWELL_LO.
- Outputs per state:
  - busy = (state != IDLE).
  - up_down = 0 in DOWN and DWELL_HI; 1 otherwise.
- done and cfg_err are registered pulses, each high for exactly one cycle.
- IDLE:
  - start=1, abort=0, lo<hi, num_sweeps!=0: latch the configuration, count <= lo, sweep_cnt <= 0, go to UP.
  - start=1 with lo>=hi or num_sweeps==0: cfg_err pulse; stay IDLE; count and sweep_cnt unchanged.
  - start=1 together with abort=1: nothing happens (abort wins).
- UP:
  - Every cycle count <= count+1.
  - On the edge where count becomes hi: go to DWELL_HI if dwell!=0, else to DOWN.
- DWELL_HI: count holds for exactly dwell cycles, then DOWN. The value hi is therefore visible for 1+dwell cycles.
- DOWN:
  - Every cycle count <= count-1.
  - On the edge where count becomes lo, a sweep completes and sweep_cnt increments.
  - If the incremented sweep_cnt equals num_sweeps: go to IDLE and pulse done in the same registered update. busy drops on that edge; count stays at lo.
  - Otherwise: go to DWELL_LO if dwell!=0, else to UP.
- DWELL_LO: count holds for exactly dwell cycles, then UP.
- Abort:
  - abort=1 in any busy state: next edge goes to IDLE, count and sweep_cnt frozen, no done pulse.
  - Abort has priority over the end-of-sweep transition on the same edge.
- Run-time isolation:
  - start while busy is ignored.
  - Changes on lo, hi, dwell or num_sweeps during a run have no effect.
- Arithmetic:
  - count is unsigned WIDTH bits and never wraps, because lo<hi bounds all motion.
  - hi = 2^WIDTH-1 and lo = 0 are legal.
- Internal dwell counter:
  - DWELL_W bits, loaded when a dwell state is entered.
  - Cleared on abort and on reset.
- Cycle example (lo=2, hi=5, dwell=0, num_sweeps=1):
  - count after the start edge: 2,3,4,5,4,3,2.
  - done is high in the cycle count first returns to 2; busy is high for 6 cycles.

Test Plan:
- Reset then run: reset_n low 2 cycles, then start with lo=2, hi=5, dwell=0, num_sweeps=1 -> count 2,3,4,5,4,3,2; done pulses once with count=2; sweep_cnt=1; busy low the same cycle; up_down 1,1,1,0,0,0.
- Dwell and repeat: lo=0, hi=3, dwell=2, num_sweeps=2 -> count 0,1,2,3,3,3,2,1,0,0,0,1,2,3,3,3,2,1,0; done on the final 0; sweep_cnt=2.
- Config errors: start with lo=5, hi=5 -> cfg_err one cycle, busy stays 0, count unchanged. Start with num_sweeps=0 -> same result.
- Abort: abort asserted while count=4 going up (lo=1, hi=9) -> next cycle busy=0, count=4 frozen, no done. A subsequent valid start restarts from the new lo with sweep_cnt=0.
- Simultaneous events:
  - start while busy -> ignored.
  - start+abort in IDLE -> no run.
  - abort on the edge where the final sweep completes -> IDLE with no done.
- Mid-run reset and boundaries:
  - reset_n=0 during DWELL_HI -> next cycle all outputs at reset values.
  - Full-range sweep lo=0, hi=15 (WIDTH=4) -> reaches 15 with no wrap.

Source files
------------

// File: rtl/sweep_counter_ctrl.sv
// Triangle-sweep sequencer: drives a bounded up/down counter from lo to hi and
// back, with optional dwell at each end point, for a programmed number of sweeps.
module sweep_counter_ctrl #(
   parameter int WIDTH   = 4,
   parameter int DWELL_W = 4,
   parameter int SWEEP_W = 8
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               start,
   input  logic               abort,
   input  logic [WIDTH-1:0]   lo,
   input  logic [WIDTH-1:0]   hi,
   input  logic [DWELL_W-1:0] dwell,
   input  logic [SWEEP_W-1:0] num_sweeps,
   output logic [WIDTH-1:0]   count,
   output logic               up_down,
   output logic               busy,
   output logic               done,
   output logic               cfg_err,
   output logic [SWEEP_W-1:0] sweep_cnt
);

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      UP       = 3'd1,
      DWELL_HI = 3'd2,
      DOWN     = 3'd3,
      DWELL_LO = 3'd4
   } state_t;

   state_t             state, state_nx;
   logic [WIDTH-1:0]   count_nx;
   logic [SWEEP_W-1:0] sweep_nx;
   logic               done_nx, cfg_err_nx;
   logic [WIDTH-1:0]   lo_q, hi_q, lo_nx, hi_nx;
   logic [DWELL_W-1:0] dwell_q, dwell_nx;
   logic [SWEEP_W-1:0] num_q, num_nx;
   logic [DWELL_W-1:0] dwell_cnt, dwell_cnt_nx;

   logic [WIDTH-1:0]   count_inc, count_dec;
   logic [SWEEP_W-1:0] sweep_inc;

   assign count_inc = count + 1'b1;
   assign count_dec = count - 1'b1;
   assign sweep_inc = sweep_cnt + 1'b1;

   assign busy    = (state != IDLE);
   assign up_down = !((state == DOWN) || (state == DWELL_HI));

   always_comb begin
      state_nx     = state;
      count_nx     = count;
      sweep_nx     = sweep_cnt;
      done_nx      = 1'b0;
      cfg_err_nx   = 1'b0;
      lo_nx        = lo_q;
      hi_nx        = hi_q;
      dwell_nx     = dwell_q;
      num_nx       = num_q;
      dwell_cnt_nx = dwell_cnt;

      // Abort outranks every transition, including the final sweep completing.
      if (abort && (state != IDLE)) begin
         state_nx     = IDLE;
         dwell_cnt_nx = '0;
      end else begin
         case (state)
            IDLE: begin
               if (start && !abort) begin
                  if ((lo < hi) && (num_sweeps != '0)) begin
                     lo_nx    = lo;
                     hi_nx    = hi;
                     dwell_nx = dwell;
                     num_nx   = num_sweeps;
                     count_nx = lo;
                     sweep_nx = '0;
                     state_nx = UP;
                  end else begin
                     cfg_err_nx = 1'b1;
                  end
               end
            end
            UP: begin
               count_nx = count_inc;
               if (count_inc == hi_q) begin
                  if (dwell_q != '0) begin
                     state_nx     = DWELL_HI;
                     dwell_cnt_nx = dwell_q;
                  end else begin
                     state_nx = DOWN;
                  end
               end
            end
            DWELL_HI: begin
               dwell_cnt_nx = dwell_cnt - 1'b1;
               if (dwell_cnt == DWELL_W'(1)) state_nx = DOWN;
            end
            DOWN: begin
               count_nx = count_dec;
               if (count_dec == lo_q) begin
                  sweep_nx = sweep_inc;
                  if (sweep_inc == num_q) begin
                     state_nx = IDLE;
                     done_nx  = 1'b1;
                  end else if (dwell_q != '0) begin
                     state_nx     = DWELL_LO;
                     dwell_cnt_nx = dwell_q;
                  end else begin
                     state_nx = UP;
                  end
               end
            end
            DWELL_LO: begin
               dwell_cnt_nx = dwell_cnt - 1'b1;
               if (dwell_cnt == DWELL_W'(1)) state_nx = UP;
            end
            default: state_nx = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state     <= IDLE;
         count     <= '0;
         sweep_cnt <= '0;
         done      <= 1'b0;
         cfg_err   <= 1'b0;
         lo_q      <= '0;
         hi_q      <= '0;
         dwell_q   <= '0;
         num_q     <= '0;
         dwell_cnt <= '0;
      end else begin
         state     <= state_nx;
         count     <= count_nx;
         sweep_cnt <= sweep_nx;
         done      <= done_nx;
         cfg_err   <= cfg_err_nx;
         lo_q      <= lo_nx;
         hi_q      <= hi_nx;
         dwell_q   <= dwell_nx;
         num_q     <= num_nx;
         dwell_cnt <= dwell_cnt_nx;
      end
   end

endmodule

// File: tb/tb_sweep_counter_ctrl.sv
// Bench for sweep_counter_ctrl: expected per-cycle outputs are built from the
// sweep shape (ramps, end-point holds, sweep counts) and compared every cycle.
module tb_sweep_counter_ctrl;

   localparam int WIDTH   = 4;
   localparam int DWELL_W = 4;
   localparam int SWEEP_W = 8;
   localparam int OW      = WIDTH + 4 + SWEEP_W;

   logic               clk = 1'b0;
   logic               reset_n = 1'b0;
   logic               start = 1'b0;
   logic               abort = 1'b0;
   logic [WIDTH-1:0]   lo = '0;
   logic [WIDTH-1:0]   hi = '0;
   logic [DWELL_W-1:0] dwell = '0;
   logic [SWEEP_W-1:0] num_sweeps = '0;
   logic [WIDTH-1:0]   count;
   logic               up_down, busy, done, cfg_err;
   logic [SWEEP_W-1:0] sweep_cnt;

   int n_tests = 0;
   int n_fail  = 0;

   // Model of what the idle block should be showing between runs.
   logic [WIDTH-1:0]   idle_count = '0;
   logic [SWEEP_W-1:0] idle_sweep = '0;

   sweep_counter_ctrl #(.WIDTH(WIDTH), .DWELL_W(DWELL_W), .SWEEP_W(SWEEP_W)) dut (
      .clk(clk), .reset_n(reset_n), .start(start), .abort(abort),
      .lo(lo), .hi(hi), .dwell(dwell), .num_sweeps(num_sweeps),
      .count(count), .up_down(up_down), .busy(busy), .done(done),
      .cfg_err(cfg_err), .sweep_cnt(sweep_cnt)
   );

   always #5 clk = ~clk;

   function automatic logic [OW-1:0] obs();
      return {count, up_down, busy, done, cfg_err, sweep_cnt};
   endfunction

   function automatic logic [OW-1:0] pack(input int c, input bit ud, input bit b,
                                          input bit dn, input bit ce, input int s);
      return {WIDTH'(c), ud, b, dn, ce, SWEEP_W'(s)};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // abort_at / rst_at: cycle index at which to disturb the run; -1 = never,
   // -2 for abort_at = the edge on which the final sweep would complete.
   task automatic run(input int l, input int h, input int d, input int n,
                      input int abort_at, input int rst_at, input string name);
      logic [OW-1:0] exp_q[$];
      logic [OW-1:0] got;
      int ab;
      exp_q.push_back(pack(l, 1, 1, 0, 0, 0));
      for (int s = 1; s <= n; s++) begin
         for (int v = l + 1; v < h; v++) exp_q.push_back(pack(v, 1, 1, 0, 0, s - 1));
         for (int k = 0; k <= d; k++) exp_q.push_back(pack(h, 0, 1, 0, 0, s - 1));
         for (int v = h - 1; v > l; v--) exp_q.push_back(pack(v, 0, 1, 0, 0, s - 1));
         if (s == n) exp_q.push_back(pack(l, 1, 0, 1, 0, s));
         else for (int k = 0; k <= d; k++) exp_q.push_back(pack(l, 1, 1, 0, 0, s));
      end
      ab = (abort_at == -2) ? exp_q.size() - 2 : abort_at;
      lo = WIDTH'(l); hi = WIDTH'(h); dwell = DWELL_W'(d); num_sweeps = SWEEP_W'(n);
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int i = 0; i < exp_q.size(); i++) begin
         got = obs();
         n_tests++;
         if (got !== exp_q[i]) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got %h expected %h", name, i, got, exp_q[i]);
         end
         if (i == ab) begin
            abort = 1'b1;
            start = 1'($urandom_range(0, 1));
            tick();
            abort = 1'b0;
            start = 1'b0;
            idle_count = exp_q[i][OW-1 -: WIDTH];
            idle_sweep = exp_q[i][SWEEP_W-1:0];
            got = obs();
            n_tests++;
            if (got !== pack(int'(idle_count), 1, 0, 0, 0, int'(idle_sweep))) begin
               n_fail++;
               $display("FAIL %s abort: got %h expected %h", name, got,
                        pack(int'(idle_count), 1, 0, 0, 0, int'(idle_sweep)));
            end
            return;
         end
         if (i == rst_at) begin
            reset_n = 1'b0;
            tick();
            reset_n = 1'b1;
            idle_count = '0;
            idle_sweep = '0;
            got = obs();
            n_tests++;
            if (got !== pack(0, 1, 0, 0, 0, 0)) begin
               n_fail++;
               $display("FAIL %s mid_reset: got %h expected %h", name, got, pack(0, 1, 0, 0, 0, 0));
            end
            return;
         end
         // While busy, scramble config and pulse start: none of it may matter.
         if (i < exp_q.size() - 1) begin
            start = 1'($urandom_range(0, 1));
            lo = WIDTH'($urandom); hi = WIDTH'($urandom);
            dwell = DWELL_W'($urandom); num_sweeps = SWEEP_W'($urandom);
         end else begin
            start = 1'b0;
         end
         tick();
      end
      idle_count = WIDTH'(l);
      idle_sweep = SWEEP_W'(n);
      got = obs();
      n_tests++;
      if (got !== pack(l, 1, 0, 0, 0, n)) begin
         n_fail++;
         $display("FAIL %s after_done: got %h expected %h", name, got, pack(l, 1, 0, 0, 0, n));
      end
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      tick();
      tick();
      n_tests++;
      if (obs() !== pack(0, 1, 0, 0, 0, 0)) begin
         n_fail++;
         $display("FAIL reset: got %h expected %h", obs(), pack(0, 1, 0, 0, 0, 0));
      end
      reset_n = 1'b1;
      tick();
      n_tests++;
      if (obs() !== pack(0, 1, 0, 0, 0, 0)) begin
         n_fail++;
         $display("FAIL reset_release: got %h expected %h", obs(), pack(0, 1, 0, 0, 0, 0));
      end
   endtask

   task automatic test_basic_sweep();
      run(2, 5, 0, 1, -1, -1, "basic");
   endtask

   task automatic test_dwell_repeat();
      run(0, 3, 2, 2, -1, -1, "dwell_repeat");
   endtask

   task automatic test_cfg_err();
      logic [OW-1:0] e;
      for (int k = 0; k < 2; k++) begin
         if (k == 0) begin lo = 4'd5; hi = 4'd5; num_sweeps = 8'd1; end
         else begin lo = 4'd1; hi = 4'd4; num_sweeps = 8'd0; end
         start = 1'b1;
         tick();
         start = 1'b0;
         e = pack(int'(idle_count), 1, 0, 0, 1, int'(idle_sweep));
         n_tests++;
         if (obs() !== e) begin
            n_fail++;
            $display("FAIL cfg_err_%0d pulse: got %h expected %h", k, obs(), e);
         end
         tick();
         e = pack(int'(idle_count), 1, 0, 0, 0, int'(idle_sweep));
         n_tests++;
         if (obs() !== e) begin
            n_fail++;
            $display("FAIL cfg_err_%0d clear: got %h expected %h", k, obs(), e);
         end
      end
   endtask

   task automatic test_abort();
      run(1, 9, 1, 2, 3, -1, "abort_mid_up");
      run(3, 6, 1, 1, -1, -1, "restart_after_abort");
   endtask

   task automatic test_start_abort_idle();
      logic [OW-1:0] e;
      lo = 4'd2; hi = 4'd7; dwell = 4'd0; num_sweeps = 8'd1;
      start = 1'b1;
      abort = 1'b1;
      tick();
      start = 1'b0;
      abort = 1'b0;
      tick();
      e = pack(int'(idle_count), 1, 0, 0, 0, int'(idle_sweep));
      n_tests++;
      if (obs() !== e) begin
         n_fail++;
         $display("FAIL start_abort_idle: got %h expected %h", obs(), e);
      end
   endtask

   task automatic test_abort_final();
      run(1, 4, 1, 2, -2, -1, "abort_final_edge");
   endtask

   task automatic test_reset_mid();
      run(2, 6, 3, 1, -1, 4, "reset_in_dwell_hi");
   endtask

   task automatic test_full_range();
      run(0, 15, 0, 1, -1, -1, "full_range");
      run(0, 15, 1, 2, -1, -1, "full_range_dwell");
   endtask

   task automatic test_random();
      int l, h, d, n, ab;
      for (int r = 0; r < 16; r++) begin
         l = $urandom_range(0, 14);
         h = $urandom_range(l + 1, 15);
         d = $urandom_range(0, 3);
         n = $urandom_range(1, 3);
         ab = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 30) : -1;
         run(l, h, d, n, ab, -1, "random");
      end
   endtask

   initial begin
      test_reset();
      test_basic_sweep();
      test_dwell_repeat();
      test_cfg_err();
      test_abort();
      test_start_abort_idle();
      test_abort_final();
      test_cfg_err();
      test_reset_mid();
      test_full_range();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
